lfsr_rx_chk: RTL and testbench
==============================

LFSR_RX_CHK -- requirements
Module: lfsr_rx_chk

Interface
REQ-001 Parameter: SYNC_WORDS, default 16 -- consecutive matching words needed to declare lock (legal 2..255).
REQ-002 Parameter: LOSS_WORDS, default 4 -- consecutive mismatching words that drop lock (legal 1..255).
REQ-003 Port: clk  in  1  -- single clock, SFP recovered rx word clock; all logic on rising edge.
REQ-004 Port: rst_n  in  1  -- asynchronous, active-low reset.
REQ-005 Port: rx_data  in  32  -- parallel word from the GTH receiver; bit 0 is the earliest serial bit.
REQ-006 Port: rx_vld  in  1  -- qualifies rx_data; words with rx_vld=0 are ignored entirely.
REQ-007 Port: clr  in  1  -- synchronous clear of all three counters.
REQ-008 Port: locked  out  1  -- high while in LOCKED state.
REQ-009 Port: lock_lost  out  1  -- one-cycle pulse on the LOCKED->HUNT transition.
REQ-010 Port: word_cnt  out  48  -- valid words checked while LOCKED, saturating.
REQ-011 Port: err_word_cnt  out  32  -- mismatching words while LOCKED, saturating.
REQ-012 Port: err_bit_cnt  out  32  -- mismatching bits while LOCKED, saturating (see Configuration).

Function
REQ-013 The pattern SHALL be PRBS31, x^31+x^28+1, serial rule s[n] = s[n-31] XOR s[n-28], the same pattern the SFP0 transmitter emits.
REQ-014 The next-word prediction P from word W SHALL be P[i] = s[32+i] computed from W's bits (1+i, 4+i), with bits i>=28 taking s[4+i] from P's own lower bits.
REQ-015 The FSM SHALL have exactly two states: HUNT (reset state) and LOCKED.
REQ-016 In HUNT, the block SHALL recompute the prediction from each received valid word (self-synchronizing reseed).
REQ-017 In HUNT, a valid word equal to the prediction and non-zero SHALL increment good_run; any other valid word SHALL clear good_run to 0.
REQ-018 An all-zero rx_data SHALL never count as a match in HUNT.
REQ-019 When good_run reaches SYNC_WORDS, the FSM SHALL enter LOCKED on the next clock; good_run SHALL clear.
REQ-020 In LOCKED, the prediction SHALL free-run from its own previous prediction, never from rx_data, so one bad word creates exactly one word error.
REQ-021 In LOCKED, each valid word SHALL increment word_cnt; a mismatch SHALL also increment err_word_cnt and add popcount(rx_data XOR prediction) to err_bit_cnt.
REQ-022 In LOCKED, bad_run SHALL increment on a mismatch and clear on a match; reaching LOSS_WORDS SHALL return the FSM to HUNT and pulse lock_lost.
REQ-023 Counter and flag latency: outputs SHALL reflect a valid word exactly 2 clocks after it is sampled (1 register stage for compare, 1 for update).
REQ-024 All counters SHALL saturate at all-ones and never wrap; err_bit_cnt SHALL saturate if the addition would overflow.
REQ-025 clr SHALL take priority over a same-cycle increment; counters read 0 on the following cycle. clr SHALL NOT affect FSM state.
REQ-026 rx_vld low for any number of cycles SHALL freeze the prediction, good_run, bad_run and counters.

Reset
REQ-027 rst_n low SHALL asynchronously force: state=HUNT, locked=0, lock_lost=0, good_run=0, bad_run=0, prediction=0, all counters 0.
REQ-028 Reset deassertion SHALL be synchronized internally; the first valid word is sampled no earlier than the second clock after release.
REQ-029 Reset during LOCKED SHALL NOT produce a lock_lost pulse.

Configuration
REQ-030 Macro LFSR_RX_CHK_BITCNT_EN defined: 32-bit popcount and err_bit_cnt implemented per REQ-021.
REQ-031 Macro LFSR_RX_CHK_BITCNT_EN undefined: no popcount logic; err_bit_cnt SHALL be constant 0; all other behaviour unchanged.

Verification
REQ-032 Clean PRBS31 stream, seed 0x00000001, rx_vld=1 continuous -> locked rises 16 words + 2 clocks after first word; err_word_cnt=0 after 10000 words.
REQ-033 While locked, XOR 0x00000005 into one word -> err_word_cnt=1, err_bit_cnt=2 (macro on) or 0 (macro off), locked stays 1.
REQ-034 While locked, corrupt 4 consecutive words -> lock_lost single pulse, locked=0, then relock after 16 clean words.
REQ-035 All-zero rx_data for 100 words from reset -> locked stays 0, all counters 0.
REQ-036 Preload err_word_cnt to 0xFFFFFFFE via forced errors, inject 3 more -> holds 0xFFFFFFFF; assert clr with an error in the same cycle -> 0.
REQ-037 rx_vld toggling 1/0 every cycle on clean stream -> lock after 16 valid words, zero errors; rst_n low while locked -> all outputs 0, no lock_lost.

Source files
------------

// File: rtl/lfsr_rx_chk.sv
// lfsr_rx_chk: PRBS31 (x^31 + x^28 + 1) receive checker for a 32-bit word stream.
// It hunts for lock by reseeding its prediction from every received word. Once
// locked, the prediction free-runs and the block counts words, word errors and
// (optionally) bit errors. Define LFSR_RX_CHK_BITCNT_EN to build the popcount
// and the err_bit_cnt counter; without it err_bit_cnt is tied to zero.
// Pipeline: a capture stage registers the input word, then a compare/update
// stage moves the FSM, runs and counters, so outputs follow a word by two clocks.
module lfsr_rx_chk #(
    parameter int unsigned SYNC_WORDS = 16,
    parameter int unsigned LOSS_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rx_data,
    input  logic        rx_vld,
    input  logic        clr,
    output logic        locked,
    output logic        lock_lost,
    output logic [47:0] word_cnt,
    output logic [31:0] err_word_cnt,
    output logic [31:0] err_bit_cnt
);
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam logic [7:0] SYNC_CNT = 8'(SYNC_WORDS);
    localparam logic [7:0] LOSS_CNT = 8'(LOSS_WORDS);

    // Next 32 stream bits after word w (bit 0 earliest): s[n] = s[n-31] ^ s[n-28].
    // The top four bits depend on s[k+32..k+35], i.e. on the low bits of the result.
    function automatic logic [31:0] prbs_next(input logic [31:0] w);
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < 28; i++) begin
            p[i] = w[i+1] ^ w[i+4];
        end
        p[28] = w[29] ^ p[0];
        p[29] = w[30] ^ p[1];
        p[30] = w[31] ^ p[2];
        p[31] = p[0]  ^ p[3];
        return p;
    endfunction

    logic        rst_meta_q, rst_sync_q;
    logic        vld_q, clr_q;
    logic [31:0] data_q;
    state_e      state_q;
    logic        locked_q, lock_lost_q;
    logic [7:0]  good_run_q, bad_run_q;
    logic [31:0] pred_q, pred_d;
    logic [47:0] word_cnt_q;
    logic [31:0] err_word_cnt_q;
    logic [31:0] diff;
    logic        mismatch, hunt_match, count_en;

    // Reset synchronizer: assertion is immediate, release takes two clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // Capture stage: register the word, its qualifier and the clear request together.
    always_ff @(posedge clk or negedge rst_sync_q) begin
        // NOTE: data_q is reset as well so the first compare after reset never sees X.
        if (!rst_sync_q) begin
            vld_q  <= 1'b0;
            clr_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= rx_vld;
            clr_q  <= clr;
            data_q <= rx_data;
        end
    end

    assign diff       = data_q ^ pred_q;
    assign mismatch   = (diff != '0);
    assign hunt_match = !mismatch && (data_q != '0);
    assign count_en   = vld_q && (state_q == LOCKED);

    // Prediction source: reseed from the received word while hunting, free-run once locked.
    always_comb begin
        // NOTE: give every always_comb output a default first so no latch can be inferred.
        pred_d = pred_q;
        if (vld_q) begin
            pred_d = (state_q == LOCKED) ? prbs_next(pred_q) : prbs_next(data_q);
        end
    end

    // Lock FSM with registered locked/lock_lost flags and the good/bad run lengths.
    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q     <= HUNT;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
            good_run_q  <= '0;
            bad_run_q   <= '0;
            pred_q      <= '0;
        end else begin
            lock_lost_q <= 1'b0;
            pred_q      <= pred_d;
            case (state_q)
                HUNT: begin
                    if (good_run_q == SYNC_CNT) begin
                        state_q    <= LOCKED;
                        locked_q   <= 1'b1;
                        good_run_q <= '0;
                        bad_run_q  <= '0;
                    end else if (vld_q) begin
                        good_run_q <= hunt_match ? good_run_q + 8'd1 : 8'd0;
                    end
                end
                LOCKED: begin
                    if (vld_q) begin
                        if (!mismatch) begin
                            bad_run_q <= '0;
                        end else if (bad_run_q + 8'd1 == LOSS_CNT) begin
                            state_q     <= HUNT;
                            locked_q    <= 1'b0;
                            lock_lost_q <= 1'b1;
                            bad_run_q   <= '0;
                        end else begin
                            bad_run_q <= bad_run_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q  <= HUNT;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    // Word and word-error counters: saturating, clear wins over a same-word increment.
    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            word_cnt_q     <= '0;
            err_word_cnt_q <= '0;
        end else if (clr_q) begin
            word_cnt_q     <= '0;
            err_word_cnt_q <= '0;
        end else if (count_en) begin
            if (word_cnt_q != '1) begin
                word_cnt_q <= word_cnt_q + 48'd1;
            end
            if (mismatch && (err_word_cnt_q != '1)) begin
                err_word_cnt_q <= err_word_cnt_q + 32'd1;
            end
        end
    end

`ifdef LFSR_RX_CHK_BITCNT_EN
    logic [31:0] err_bit_cnt_q;
    logic [5:0]  pop;
    logic [32:0] bit_sum;

    // Popcount of the error pattern and the widened sum used for saturation.
    always_comb begin
        pop = '0;
        for (int i = 0; i < 32; i++) begin
            pop = pop + 6'(diff[i]);
        end
        bit_sum = {1'b0, err_bit_cnt_q} + 33'(pop);
    end

    // Bit-error counter: pins at all-ones when the addition carries out.
    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            err_bit_cnt_q <= '0;
        end else if (clr_q) begin
            err_bit_cnt_q <= '0;
        end else if (count_en && mismatch) begin
            err_bit_cnt_q <= bit_sum[32] ? '1 : bit_sum[31:0];
        end
    end

    assign err_bit_cnt = err_bit_cnt_q;
`else
    assign err_bit_cnt = '0;
`endif

    assign locked       = locked_q;
    assign lock_lost    = lock_lost_q;
    assign word_cnt     = word_cnt_q;
    assign err_word_cnt = err_word_cnt_q;
endmodule

// File: tb/tb_lfsr_rx_chk.sv
// Bench for lfsr_rx_chk: directed scenarios plus a randomized phase. The reference
// model works on whole words, with predictions generated bit by bit from the PRBS31
// serial rule. Every driven cycle pushes its expected outputs into a queue, and an
// independent monitor compares them two clocks later.
module tb_lfsr_rx_chk;
    localparam int SYNC = 16;
    localparam int LOSS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_vld = 1'b0;
    logic        clr = 1'b0;
    logic        locked, lock_lost;
    logic [47:0] word_cnt;
    logic [31:0] err_word_cnt, err_bit_cnt;

    lfsr_rx_chk #(.SYNC_WORDS(SYNC), .LOSS_WORDS(LOSS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_vld       (rx_vld),
        .clr          (clr),
        .locked       (locked),
        .lock_lost    (lock_lost),
        .word_cnt     (word_cnt),
        .err_word_cnt (err_word_cnt),
        .err_bit_cnt  (err_bit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        locked;
        logic        lost;
        logic [47:0] wc;
        logic [31:0] ew;
        logic [31:0] eb;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic        prev_locked = 1'b0;
    int          lock_rise_cyc = -1;
    int          lost_pulses = 0;
    logic [31:0] tx;

    // Reference model state
    bit          m_locked, m_pending, m_lost;
    int          m_good, m_bad;
    logic [31:0] m_pred;
    logic [47:0] m_wc;
    logic [31:0] m_ew, m_eb;

    // Following 32 bits of the stream, straight from the serial recurrence.
    function automatic logic [31:0] prbs_after(input logic [31:0] w);
        bit s[64];
        logic [31:0] r;
        for (int n = 0; n < 32; n++) s[n] = w[n];
        for (int n = 32; n < 64; n++) s[n] = s[n-31] ^ s[n-28];
        for (int n = 0; n < 32; n++) r[n] = s[n+32];
        return r;
    endfunction

    // First word of the stream from a 31-bit register seed.
    function automatic logic [31:0] prbs_from_seed(input logic [30:0] seed);
        logic [31:0] r;
        for (int n = 0; n < 31; n++) r[n] = seed[n];
        r[31] = seed[0] ^ seed[3];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_pending = 0; m_lost = 0;
        m_good = 0; m_bad = 0; m_pred = '0;
        m_wc = '0; m_ew = '0; m_eb = '0;
    endtask

    // One clock of behaviour for the word offered in this cycle.
    task automatic model_step(input logic v, input logic [31:0] d, input logic c);
        bit          was_locked;
        bit          miss;
        logic [31:0] old_pred;
        logic [32:0] s;
        was_locked = m_locked;
        old_pred   = m_pred;
        miss       = (d != m_pred);
        m_lost     = 0;
        if (!m_locked) begin
            if (m_pending) begin
                m_locked = 1; m_pending = 0; m_good = 0; m_bad = 0;
            end else if (v) begin
                m_good = (d != 0 && !miss) ? m_good + 1 : 0;
                if (m_good == SYNC) m_pending = 1;
            end
            if (v) m_pred = prbs_after(d);
        end else if (v) begin
            m_pred = prbs_after(m_pred);
            if (miss) begin
                m_bad++;
                if (m_bad == LOSS) begin
                    m_locked = 0; m_lost = 1; m_bad = 0;
                end
            end else begin
                m_bad = 0;
            end
        end
        if (c) begin
            m_wc = '0; m_ew = '0; m_eb = '0;
        end else if (was_locked && v) begin
            if (m_wc != '1) m_wc++;
            if (miss) begin
                if (m_ew != '1) m_ew++;
`ifdef LFSR_RX_CHK_BITCNT_EN
                s = {1'b0, m_eb} + 33'($countones(d ^ old_pred));
                m_eb = s[32] ? '1 : s[31:0];
`endif
            end
        end
        exp_q.push_back('{m_locked, m_lost, m_wc, m_ew, m_eb});
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic c);
        @(negedge clk);
        rx_vld = v; rx_data = d; clr = c;
        model_step(v, d, c);
    endtask

    task automatic send_good(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, tx, 1'b0);
            tx = prbs_after(tx);
        end
    endtask

    task automatic send_bad(input logic [31:0] mask, input logic c);
        drive(1'b1, tx ^ mask, c);
        tx = prbs_after(tx);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom, 1'b0);
    endtask

    task automatic do_reset(input bit chk);
        int lost_before;
        @(negedge clk);
        mon_en = 0;
        exp_q.delete();
        rx_vld = 0; clr = 0;
        lost_before = lost_pulses;
        rst_n = 0;
        #1;
        if (chk) begin
            check("rst_locked", locked, 0);
            check("rst_lock_lost", lock_lost, 0);
            check("rst_word_cnt", word_cnt, 0);
            check("rst_err_word_cnt", err_word_cnt, 0);
            check("rst_err_bit_cnt", err_bit_cnt, 0);
        end
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1;
        mon_en = 1;
        idle(3);
        if (chk) check("rst_no_lock_lost", lost_pulses, lost_before);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: output of the word driven two cycles ago is due now.
    always @(posedge clk) begin
        #1;
        if (lock_lost) lost_pulses++;
        if (mon_en && exp_q.size() >= 2) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if (locked !== mon_e.locked || lock_lost !== mon_e.lost || word_cnt !== mon_e.wc ||
                err_word_cnt !== mon_e.ew || err_bit_cnt !== mon_e.eb) begin
                n_errors++;
                $display("FAIL scoreboard cyc=%0d got lk=%b ll=%b wc=%0d ew=%0h eb=%0h expected lk=%b ll=%b wc=%0d ew=%0h eb=%0h",
                         cyc, locked, lock_lost, word_cnt, err_word_cnt, err_bit_cnt,
                         mon_e.locked, mon_e.lost, mon_e.wc, mon_e.ew, mon_e.eb);
            end
            if (locked && !prev_locked && lock_rise_cyc < 0) lock_rise_cyc = cyc;
        end
        prev_locked = locked;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_cyc;
        int burst;
        logic [31:0] m;
        bit v, c;

        model_reset();
        do_reset(1'b0);

        // All-zero words from reset never lock and never count.
        for (int i = 0; i < 100; i++) drive(1'b1, 32'h0, 1'b0);
        idle(3);
        check("zero_locked", locked, 0);
        check("zero_word_cnt", word_cnt, 0);
        check("zero_err_word_cnt", err_word_cnt, 0);
        check("zero_err_bit_cnt", err_bit_cnt, 0);

        // Clean stream from seed 1: lock time and 10000 error-free words.
        do_reset(1'b1);
        tx = prbs_from_seed(31'h1);
        lock_rise_cyc = -1;
        send_good(1);
        first_cyc = cyc + 1;
        send_good(9999);
        idle(3);
        check("lock_latency", lock_rise_cyc - first_cyc, SYNC + 2);
        check("clean_locked", locked, 1);
        check("clean_err_word_cnt", err_word_cnt, 0);
        check("clean_err_bit_cnt", err_bit_cnt, 0);

        // Single word hit by 0x5 while locked.
        send_bad(32'h5, 1'b0);
        send_good(4);
        idle(3);
        check("one_err_word_cnt", err_word_cnt, 1);
`ifdef LFSR_RX_CHK_BITCNT_EN
        check("one_err_bit_cnt", err_bit_cnt, 2);
`else
        check("one_err_bit_cnt", err_bit_cnt, 0);
`endif
        check("one_err_locked", locked, 1);

        // LOSS consecutive bad words drop lock with one pulse, then relock.
        first_cyc = lost_pulses;
        for (int i = 0; i < LOSS; i++) send_bad($urandom | 32'h1, 1'b0);
        idle(3);
        check("loss_pulses", lost_pulses - first_cyc, 1);
        check("loss_unlocked", locked, 0);
        send_good(SYNC - 1);
        idle(4);
        check("relock_early", locked, 0);
        send_good(1);
        idle(4);
        check("relock_locked", locked, 1);

        // Counters near saturation, then clear against a same-word error.
        @(negedge clk);
        force dut.err_word_cnt_q = 32'hFFFF_FFFE;
        m_ew = 32'hFFFF_FFFE;
`ifdef LFSR_RX_CHK_BITCNT_EN
        force dut.err_bit_cnt_q = 32'hFFFF_FFFD;
        m_eb = 32'hFFFF_FFFD;
`endif
        #1;
        release dut.err_word_cnt_q;
`ifdef LFSR_RX_CHK_BITCNT_EN
        release dut.err_bit_cnt_q;
`endif
        foreach (exp_q[i]) begin
            exp_q[i].ew = m_ew;
            exp_q[i].eb = m_eb;
        end
        for (int i = 0; i < 3; i++) begin
            send_bad(32'h5, 1'b0);
            send_good(2);
        end
        idle(3);
        check("sat_err_word_cnt", err_word_cnt, 32'hFFFF_FFFF);
`ifdef LFSR_RX_CHK_BITCNT_EN
        check("sat_err_bit_cnt", err_bit_cnt, 32'hFFFF_FFFF);
`endif
        send_bad(32'h5, 1'b1);
        idle(3);
        check("clr_err_word_cnt", err_word_cnt, 0);
        check("clr_word_cnt", word_cnt, 0);
        check("clr_err_bit_cnt", err_bit_cnt, 0);
        check("clr_keeps_lock", locked, 1);

        // Randomized traffic: gaps, bit errors, error bursts and clears.
        burst = 0;
        for (int k = 0; k < 3000; k++) begin
            v = ($urandom_range(0, 99) < 75);
            c = ($urandom_range(0, 249) == 0);
            m = '0;
            if (v) begin
                if (burst > 0) begin
                    m = $urandom | 32'h1;
                    burst--;
                end else if ($urandom_range(0, 39) == 0) begin
                    m = 32'h1 << $urandom_range(0, 31);
                end else if ($urandom_range(0, 299) == 0) begin
                    burst = LOSS + $urandom_range(0, 2);
                end
                drive(1'b1, tx ^ m, c);
                tx = prbs_after(tx);
            end else begin
                drive(1'b0, $urandom, c);
            end
        end
        idle(3);

        // rx_vld toggling every cycle: lock after SYNC valid words past the reseed.
        do_reset(1'b1);
        tx = prbs_from_seed(31'h1);
        for (int i = 0; i < SYNC; i++) begin
            send_good(1);
            idle(1);
        end
        idle(4);
        check("toggle_not_yet", locked, 0);
        for (int i = 0; i < 200; i++) begin
            send_good(1);
            idle(1);
        end
        idle(3);
        check("toggle_locked", locked, 1);
        check("toggle_err_word_cnt", err_word_cnt, 0);

        // Reset while locked: outputs clear, no lock_lost pulse.
        do_reset(1'b1);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
